mem_responder: RTL and testbench

Memory-side responder for the core's single-port bus (address, write data, read data, write enable). It decodes each bus cycle into a word-addressed RAM or a small MMIO block: a console output FIFO, a 64-bit cycle timer and a halt/exit register. It sits directly opposite the core in the top level and is the only target on that bus. All reads complete with a fixed one-cycle latency, and there is no wait state.

---
 rtl/mem_responder_if.sv | 11 +
 rtl/mem_responder.sv | 151 +++++++++++++++
 tb/tb_mem_responder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Single-port core bus: byte address, write data, write enable, registered read data.
// The core is the master; mem_responder is the only slave on the bus.
interface mem_responder_if;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (output address, output wdata, output we, input rdata);
  modport slave  (input address, input wdata, input we, output rdata);
endinterface

// File: rtl/mem_responder.sv
// Bus responder: word-addressed RAM plus MMIO (console FIFO, 64-bit timer, halt register).
// Every cycle is a read with one-cycle registered latency; writes commit on the same edge.
module mem_responder #(
  parameter int MEM_WORDS  = 4096,
  parameter     INIT_FILE  = "",
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  mem_responder_if.slave    bus,
  output logic [7:0]        console_data,
  output logic              console_valid,
  input  logic              console_ready,
  output logic              halted,
  output logic [31:0]       exit_code
);

  localparam int RAM_AW = $clog2(MEM_WORDS);
  localparam int FAW    = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  localparam logic [2:0] OFF_CONSOLE = 3'd0;
  localparam logic [2:0] OFF_STATUS  = 3'd1;
  localparam logic [2:0] OFF_TLO     = 3'd2;
  localparam logic [2:0] OFF_THI     = 3'd3;
  localparam logic [2:0] OFF_HALT    = 3'd4;

  logic [31:0]       r_mem [MEM_WORDS];
  logic [31:0]       r_ram_q;
  logic              r_rd_is_ram;
  logic [31:0]       r_mmio_q;

  logic [7:0]        r_fifo [FIFO_DEPTH];
  logic [FAW-1:0]    r_rd_ptr;
  logic [FAW-1:0]    r_wr_ptr;
  logic [4:0]        r_count;
  logic              r_overflow;

  logic [63:0]       r_counter;
  logic [31:0]       r_shadow;
  logic              r_halted;
  logic [31:0]       r_exit_code;

  logic              w_is_ram;
  logic              w_is_mmio;
  logic [2:0]        w_off;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_wr_console;
  logic              w_wr_tlo;
  logic              w_wr_halt;
  logic              w_rd_tlo;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [31:0]       w_status;
  logic [31:0]       w_mmio_rd;
  logic              w_unused_ok;

  assign w_is_ram     = ~bus.address[31];
  assign w_is_mmio    = bus.address[31] && (bus.address[30:5] == 26'd0);
  assign w_off        = bus.address[4:2];
  assign w_ram_idx    = bus.address[RAM_AW+1:2];
  assign w_wr_console = bus.we && w_is_mmio && (w_off == OFF_CONSOLE);
  assign w_wr_tlo     = bus.we && w_is_mmio && (w_off == OFF_TLO);
  assign w_wr_halt    = bus.we && w_is_mmio && (w_off == OFF_HALT);
  // Every bus cycle is also a read, so a TIMER_LO write snapshots the high word too.
  assign w_rd_tlo     = w_is_mmio && (w_off == OFF_TLO);
  assign w_unused_ok  = &{1'b0, bus.address[1:0]};

  // Full is judged on pre-edge count: a push at full is dropped even when a pop frees a slot.
  assign w_full   = (r_count == DEPTH_C);
  assign w_push   = w_wr_console && !w_full;
  assign w_pop    = (r_count != 5'd0) && console_ready;
  assign w_status = {24'd0, r_overflow, r_count, (r_count == 5'd0), w_full};

  always_comb begin
    w_mmio_rd = 32'hDEAD_BEEF;
    if (w_is_mmio) begin
      case (w_off)
        OFF_CONSOLE, OFF_STATUS: w_mmio_rd = w_status;
        OFF_TLO:                 w_mmio_rd = r_counter[31:0];
        OFF_THI:                 w_mmio_rd = r_shadow;
        OFF_HALT:                w_mmio_rd = {31'd0, r_halted};
        default:                 w_mmio_rd = 32'hDEAD_BEEF;
      endcase
    end
  end

  // RAM is deliberately outside reset; read-first ordering returns the old word on a write.
  always_ff @(posedge clk) begin
    if (bus.we && w_is_ram) r_mem[w_ram_idx] <= bus.wdata;
    r_ram_q <= r_mem[w_ram_idx];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_is_ram <= 1'b0;
      r_mmio_q    <= 32'd0;
    end else begin
      r_rd_is_ram <= w_is_ram;
      r_mmio_q    <= w_mmio_rd;
    end
  end

  assign bus.rdata = r_rd_is_ram ? r_ram_q : r_mmio_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= 8'd0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= 5'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= bus.wdata[7:0];
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_console && w_full) r_overflow <= 1'b1;
      r_count <= r_count + {4'd0, w_push} - {4'd0, w_pop};
    end
  end

  assign console_data  = r_fifo[r_rd_ptr];
  assign console_valid = (r_count != 5'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_counter <= 64'd0;
      r_shadow  <= 32'd0;
    end else begin
      r_counter <= w_wr_tlo ? 64'd0 : r_counter + 64'd1;
      if (w_rd_tlo) r_shadow <= r_counter[63:32];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_halted    <= 1'b0;
      r_exit_code <= 32'd0;
    end else if (w_wr_halt && !r_halted) begin
      r_halted    <= 1'b1;
      r_exit_code <= bus.wdata;
    end
  end

  assign halted    = r_halted;
  assign exit_code = r_exit_code;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios then random bus traffic, all checked
// against a transaction-level model (assoc-array RAM, byte queue, cycle counter).
module tb_mem_responder;

  localparam int MEM_WORDS  = 256;
  localparam int FIFO_DEPTH = 4;

  localparam logic [31:0] A_CONSOLE = 32'h8000_0000;
  localparam logic [31:0] A_STATUS  = 32'h8000_0004;
  localparam logic [31:0] A_TLO     = 32'h8000_0008;
  localparam logic [31:0] A_THI     = 32'h8000_000C;
  localparam logic [31:0] A_HALT    = 32'h8000_0010;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  console_data;
  logic        console_valid;
  logic        console_ready = 1'b0;
  logic        halted;
  logic [31:0] exit_code;

  mem_responder_if bus ();

  mem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .INIT_FILE (""),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus.slave),
    .console_data (console_data),
    .console_valid(console_valid),
    .console_ready(console_ready),
    .halted       (halted),
    .exit_code    (exit_code)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [7:0]  m_fifo [$];
  bit          m_ovf;
  logic [63:0] m_cnt;
  logic [31:0] m_shadow;
  bit          m_halted;
  logic [31:0] m_exit;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    int sz = m_fifo.size();
    logic [31:0] s = 32'd0;
    if (m_ovf) s = s | 32'h80;
    s = s | (32'(sz) << 2);
    if (sz == 0) s = s | 32'h2;
    if (sz == FIFO_DEPTH) s = s | 32'h1;
    return s;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_ovf    = 0;
    m_cnt    = 64'd0;
    m_shadow = 32'd0;
    m_halted = 0;
    m_exit   = 32'd0;
  endtask

  // One bus cycle: drive at negedge, model the edge, check #1 later, return at next negedge.
  task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic w, input logic rdy);
    int          sz;
    int          idx;
    int          off;
    bit          known;
    bit          is_mmio;
    logic [31:0] exp;
    bus.address   = a;
    bus.wdata     = d;
    bus.we        = w;
    console_ready = rdy;
    @(posedge clk);
    sz      = m_fifo.size();
    known   = 1;
    exp     = 32'hDEAD_BEEF;
    is_mmio = a[31] && ((a & 32'h7FFF_FFE0) == 32'd0);
    off     = int'((a >> 2) & 32'd7);
    if (!a[31]) begin
      idx = int'((a >> 2) % MEM_WORDS);
      if (m_ram.exists(idx)) exp = m_ram[idx];
      else known = 0;
      if (w) m_ram[idx] = d;
    end else if (is_mmio) begin
      case (off)
        0, 1: exp = model_status();
        2:    exp = m_cnt[31:0];
        3:    exp = m_shadow;
        4:    known = 0;
        default: exp = 32'hDEAD_BEEF;
      endcase
    end
    if (is_mmio && off == 2) m_shadow = m_cnt[63:32];
    if (is_mmio && off == 2 && w) m_cnt = 64'd0;
    else m_cnt = m_cnt + 64'd1;
    if (is_mmio && off == 4 && w && !m_halted) begin
      m_halted = 1;
      m_exit   = d;
    end
    if (sz > 0 && rdy) void'(m_fifo.pop_front());
    if (is_mmio && off == 0 && w) begin
      if (sz < FIFO_DEPTH) m_fifo.push_back(d[7:0]);
      else m_ovf = 1;
    end
    #1;
    if (known) check("rdata", 64'(bus.rdata), 64'(exp));
    check("console_valid", 64'(console_valid), 64'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) check("console_data", 64'(console_data), 64'(m_fifo[0]));
    check("halted", 64'(halted), 64'(m_halted));
    check("exit_code", 64'(exit_code), 64'(m_exit));
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2;
    resetn = 1'b0;
    #1;
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_exit", 64'(exit_code), 64'd0);
    check("rst_valid", 64'(console_valid), 64'd0);
    check("rst_cdata", 64'(console_data), 64'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          sel;
    bus.address = 32'd0;
    bus.wdata   = 32'd0;
    bus.we      = 1'b0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    do_reset();

    // RAM write, read-back and address aliasing
    cycle(32'h0000_0040, 32'h1234_5678, 1'b1, 1'b0);
    cycle(32'h0000_0040, 32'd0, 1'b0, 1'b0);
    check("ram_read", 64'(bus.rdata), 64'h1234_5678);
    cycle(32'h0000_0040 + 32'(4 * MEM_WORDS), 32'd0, 1'b0, 1'b0);
    check("ram_alias", 64'(bus.rdata), 64'h1234_5678);

    // Read-first on word 0x10
    cycle(32'h0000_0040, 32'h0000_0005, 1'b1, 1'b0);
    cycle(32'h0000_0040, 32'hAAAA_AAAA, 1'b1, 1'b0);
    check("read_first_old", 64'(bus.rdata), 64'h5);
    cycle(32'h0000_0040, 32'd0, 1'b0, 1'b0);
    check("read_first_new", 64'(bus.rdata), 64'hAAAA_AAAA);

    // Console overflow: five pushes into a four-deep FIFO
    for (int i = 0; i < 5; i++) cycle(A_CONSOLE, 32'h41 + 32'(i), 1'b1, 1'b0);
    cycle(A_STATUS, 32'd0, 1'b0, 1'b0);
    check("status_overflow", 64'(bus.rdata), 64'h91);
    for (int i = 0; i < 4; i++) begin
      check("drain_byte", 64'(console_data), 64'h41 + 64'(i));
      cycle(A_STATUS, 32'd0, 1'b0, 1'b1);
    end
    check("drain_empty", 64'(console_valid), 64'd0);

    // Mid-run reset clears FIFO state but RAM persists
    do_reset();
    cycle(32'h0000_0040, 32'd0, 1'b0, 1'b0);
    check("ram_persist", 64'(bus.rdata), 64'hAAAA_AAAA);

    // Full FIFO with simultaneous push and pop: push dropped
    for (int i = 0; i < 4; i++) cycle(A_CONSOLE, 32'h61 + 32'(i), 1'b1, 1'b0);
    cycle(A_CONSOLE, 32'h7A, 1'b1, 1'b1);
    cycle(A_STATUS, 32'd0, 1'b0, 1'b0);
    check("full_push_pop", 64'(bus.rdata), 64'h8C);
    for (int i = 0; i < 3; i++) cycle(A_STATUS, 32'd0, 1'b0, 1'b1);

    // Timer: clear, ten cycles, read
    cycle(A_TLO, 32'hFFFF_FFFF, 1'b1, 1'b0);
    repeat (10) cycle(A_STATUS, 32'd0, 1'b0, 1'b0);
    cycle(A_TLO, 32'd0, 1'b0, 1'b0);
    check("timer_10", 64'(bus.rdata), 64'd10);

    // Timer near 2^32: HI returns the snapshot from the last LO read, not the live count
    force dut.r_counter = 64'h0000_0000_FFFF_FFF8;
    m_cnt = 64'h0000_0000_FFFF_FFF8;
    #1;
    release dut.r_counter;
    cycle(A_TLO, 32'd0, 1'b0, 1'b0);
    check("timer_lo_pre", 64'(bus.rdata), 64'hFFFF_FFF8);
    repeat (10) cycle(A_STATUS, 32'd0, 1'b0, 1'b0);
    cycle(A_THI, 32'd0, 1'b0, 1'b0);
    check("timer_hi_stale", 64'(bus.rdata), 64'd0);
    cycle(A_TLO, 32'd0, 1'b0, 1'b0);
    cycle(A_THI, 32'd0, 1'b0, 1'b0);
    check("timer_hi_carry", 64'(bus.rdata), 64'd1);

    // Unmapped MMIO
    cycle(32'h8000_0020, 32'd0, 1'b0, 1'b0);
    check("unmapped", 64'(bus.rdata), 64'hDEAD_BEEF);

    // Halt: first write sticks
    cycle(A_HALT, 32'h2A, 1'b1, 1'b0);
    cycle(A_HALT, 32'h7, 1'b1, 1'b0);
    check("halt_flag", 64'(halted), 64'd1);
    check("halt_code", 64'(exit_code), 64'h2A);

    // Random traffic with a reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      sel = int'($urandom_range(0, 9));
      d   = $urandom;
      if (sel < 5) begin
        a = ($urandom & 32'h7FFF_0000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      end else if (sel < 9) begin
        a = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 2);
      end else begin
        a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
      end
      cycle(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
